// File: rtl/viterbi_pkg.sv
// viterbi_pkg
//   Shared definitions for the rate-1/2, K=3 convolutional code
//   (G0=111, G1=101) used by viterbi_encoder, viterbi_decoder and the benches.
//   Contents: code constants, initial path metric, expected_sym() and a
//   2-bit Hamming-distance helper.
package viterbi_pkg;

   localparam int K       = 3;
   localparam int NSTATES = 4;
   localparam logic [K-1:0] G0 = 3'b111;
   localparam logic [K-1:0] G1 = 3'b101;
   localparam int INIT_PM = 16;

   // Code symbol {g0,g1} emitted when bit b enters the encoder in state
   // s={x[n-1],x[n-2]}. The shift register is laid out as {b, s[1], s[0]}.
   function automatic logic [1:0] expected_sym(input logic [1:0] state, input logic b);
      logic [K-1:0] taps;
      taps = {b, state};
      return {^(taps & G0), ^(taps & G1)};
   endfunction

   // Hamming distance between two 2-bit symbols (0..2).
   function automatic logic [1:0] hamming2(input logic [1:0] a, input logic [1:0] c);
      logic [1:0] d;
      d = a ^ c;
      return {1'b0, d[1]} + {1'b0, d[0]};
   endfunction

endpackage

// File: rtl/viterbi_acs.sv
// viterbi_acs
//   Compare-select half of one add-compare-select cell. The adds are done by
//   the caller so this cell stays a pure two-way minimum.
//   Ports:
//     cand_a  in  MW+1  candidate metric through predecessor sa={p,0}
//     cand_b  in  MW+1  candidate metric through predecessor sb={p,1}
//     metric  out MW+1  surviving (minimum) candidate
//     dec     out 1     1 when sb survives
module viterbi_acs #(
   parameter int MW = 6
) (
   input  logic [MW:0] cand_a,
   input  logic [MW:0] cand_b,
   output logic [MW:0] metric,
   output logic        dec
);

   // sb must be strictly better; equal metrics keep sa.
   assign dec    = (cand_b < cand_a);
   assign metric = dec ? cand_b : cand_a;

endmodule

// File: rtl/viterbi_decoder.sv
// viterbi_decoder
//   Hard-decision Viterbi decoder for the rate-1/2, K=3 code (G0=111, G1=101).
//   4-state ACS with min-subtraction normalisation and register-exchange
//   survivors of TB_DEPTH bits. One decoded bit per accepted symbol once the
//   survivors are full; bit k leaves on the edge accepting symbol k+TB_DEPTH-1.
//   Ports:
//     clk        in  1  rising-edge clock
//     reset      in  1  asynchronous active-high reset
//     in_valid   in  1  y accepted on this edge
//     y          in  2  received symbol, y[1]=g0, y[0]=g1
//     out_valid  out 1  registered, one pulse per decoded bit
//     x_hat      out 1  registered decoded bit
module viterbi_decoder
   import viterbi_pkg::*;
#(
   parameter int TB_DEPTH = 16,
   parameter int MW       = 6
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       in_valid,
   input  logic [1:0] y,
   output logic       out_valid,
   output logic       x_hat
);

   localparam int FW = $clog2(TB_DEPTH);
   localparam logic [FW-1:0] FILL_MAX = FW'(TB_DEPTH - 1);
   localparam logic [MW-1:0] PM_INIT  = MW'(INIT_PM);

   logic [NSTATES-1:0][MW-1:0]       pm_reg;
   logic [NSTATES-1:0][MW-1:0]       pm_next;
   logic [NSTATES-1:0][TB_DEPTH-1:0] sv_reg;
   logic [NSTATES-1:0][TB_DEPTH-1:0] sv_next;
   logic [FW-1:0]                    fill_reg;

   logic [NSTATES-1:0][MW:0] acs_metric;
   logic [NSTATES-1:0]       acs_dec;
   logic [MW:0]              min_metric;
   logic [1:0]               best;

   // One ACS cell per next state ns={b,p}; predecessors are {p,0} and {p,1}.
   generate
      for (genvar gi = 0; gi < NSTATES; gi++) begin : g_state
         localparam int   P    = gi % 2;
         localparam int   SA   = 2 * P;
         localparam int   SB   = SA + 1;
         localparam logic NS_B = 1'(gi / 2);

         logic [1:0] bm_a;
         logic [1:0] bm_b;
         logic [MW:0] cand_a;
         logic [MW:0] cand_b;

         assign bm_a   = hamming2(y, expected_sym(2'(SA), NS_B));
         assign bm_b   = hamming2(y, expected_sym(2'(SB), NS_B));
         assign cand_a = {1'b0, pm_reg[SA]} + (MW+1)'(bm_a);
         assign cand_b = {1'b0, pm_reg[SB]} + (MW+1)'(bm_b);

         viterbi_acs #(.MW(MW)) u_acs (
            .cand_a (cand_a),
            .cand_b (cand_b),
            .metric (acs_metric[gi]),
            .dec    (acs_dec[gi])
         );

         // Winners never exceed the minimum by more than INIT_PM+4, so the
         // normalised value always fits back into MW bits.
         assign pm_next[gi] = MW'(acs_metric[gi] - min_metric);

         assign sv_next[gi] = {acs_dec[gi] ? sv_reg[SB][TB_DEPTH-2:0]
                                           : sv_reg[SA][TB_DEPTH-2:0], NS_B};
      end
   endgenerate

   // Minimum winner and the lowest-index state that holds it.
   always_comb begin
      min_metric = acs_metric[0];
      best       = 2'd0;
      for (int i = 1; i < NSTATES; i++) begin
         if (acs_metric[i] < min_metric) begin
            min_metric = acs_metric[i];
            best       = 2'(i);
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSTATES; i++) begin
            pm_reg[i] <= (i == 0) ? '0 : PM_INIT;
         end
         sv_reg    <= '0;
         fill_reg  <= '0;
         out_valid <= 1'b0;
         x_hat     <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (in_valid) begin
            pm_reg <= pm_next;
            sv_reg <= sv_next;
            if (fill_reg != FILL_MAX) begin
               fill_reg <= fill_reg + FW'(1);
            end
            // fill_reg still counts the symbols before this one, so the
            // first pulse lands on the TB_DEPTH-th accepted symbol.
            out_valid <= (fill_reg >= FILL_MAX);
            x_hat     <= sv_next[best][TB_DEPTH-1];
         end
      end
   end

endmodule
